// File: rtl/split_2o.sv
// Channel splitter: routes the first DEPTH_1 channels of each spatial position to port 1 and the next DEPTH_2 to port 2.
// Optional frame_done pulse output is enabled by defining SPLIT_FRAME_DONE_EN.
module split_2o #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_1    = 1,
   parameter int DEPTH_2    = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out_1,
   output logic                  valid_out_1,
   output logic [DATA_WIDTH-1:0] pxl_out_2,
`ifdef SPLIT_FRAME_DONE_EN
   output logic                  frame_done,
`endif
   output logic                  valid_out_2
);

   localparam int MAX_D = (DEPTH_1 > DEPTH_2) ? DEPTH_1 : DEPTH_2;
   localparam int CW    = $clog2(MAX_D) + 1;
   localparam int NPOS  = WIDTH * WIDTH;
   localparam int PW    = $clog2(NPOS) + 1;

   localparam logic [CW-1:0] CH_LAST_1 = CW'(DEPTH_1 - 1);
   localparam logic [CW-1:0] CH_LAST_2 = CW'(DEPTH_2 - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(NPOS - 1);
   localparam logic [CW-1:0] CH_ONE    = CW'(1);
   localparam logic [PW-1:0] POS_ONE   = PW'(1);

   typedef enum logic [0:0] {
      SEL1 = 1'b0,
      SEL2 = 1'b1
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   ch_cnt_r, ch_cnt_s;
   logic [PW-1:0]   pos_cnt_r, pos_cnt_s;
   logic            sel1_s, sel2_s, last_pix_s;

   logic [DATA_WIDTH-1:0] pxl_out_1_r, pxl_out_2_r;
   logic                  valid_out_1_r, valid_out_2_r;

   // Control state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= SEL1;
         ch_cnt_r  <= '0;
         pos_cnt_r <= '0;
      end else begin
         state_r   <= state_s;
         ch_cnt_r  <= ch_cnt_s;
         pos_cnt_r <= pos_cnt_s;
      end
   end

   // Next-state and routing decode; everything holds on gap cycles
   always_comb begin
      state_s    = state_r;
      ch_cnt_s   = ch_cnt_r;
      pos_cnt_s  = pos_cnt_r;
      sel1_s     = 1'b0;
      sel2_s     = 1'b0;
      last_pix_s = 1'b0;
      if (valid_in) begin
         case (state_r)
            SEL1: begin
               sel1_s = 1'b1;
               if (ch_cnt_r == CH_LAST_1) begin
                  ch_cnt_s = '0;
                  state_s  = SEL2;
               end else begin
                  ch_cnt_s = ch_cnt_r + CH_ONE;
               end
            end
            SEL2: begin
               sel2_s = 1'b1;
               if (ch_cnt_r == CH_LAST_2) begin
                  ch_cnt_s = '0;
                  state_s  = SEL1;
                  // Last channel of the last position closes the frame
                  if (pos_cnt_r == POS_LAST) begin
                     pos_cnt_s  = '0;
                     last_pix_s = 1'b1;
                  end else begin
                     pos_cnt_s = pos_cnt_r + POS_ONE;
                  end
               end else begin
                  ch_cnt_s = ch_cnt_r + CH_ONE;
               end
            end
            default: begin
               state_s  = SEL1;
               ch_cnt_s = '0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Output registers: one-cycle latency, data held while its port is idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pxl_out_1_r   <= '0;
         pxl_out_2_r   <= '0;
         valid_out_1_r <= 1'b0;
         valid_out_2_r <= 1'b0;
      end else begin
         valid_out_1_r <= sel1_s;
         valid_out_2_r <= sel2_s;
         if (sel1_s) begin
            pxl_out_1_r <= pxl_in;
         end
         if (sel2_s) begin
            pxl_out_2_r <= pxl_in;
         end
      end
   end

   assign pxl_out_1   = pxl_out_1_r;
   assign pxl_out_2   = pxl_out_2_r;
   assign valid_out_1 = valid_out_1_r;
   assign valid_out_2 = valid_out_2_r;

`ifdef SPLIT_FRAME_DONE_EN
   logic frame_done_r;

   // End-of-frame pulse aligned with the final port-2 output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= last_pix_s;
      end
   end

   assign frame_done = frame_done_r;
`else
   logic unused_last_s;
   assign unused_last_s = last_pix_s;
`endif

endmodule

// File: tb/tb_split_2o.sv
// Randomised self-checking bench for split_2o: two instances (W=2,D=2/3 and W=8,D=1/1) share one stimulus stream.
// Expected routing is derived from the accepted-pixel index since reset.
`timescale 1ns/1ps
module tb_split_2o;

   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          valid_in;
   logic [DW-1:0] pxl_in;

   logic [DW-1:0] a_p1, a_p2, b_p1, b_p2;
   logic          a_v1, a_v2, b_v1, b_v2;
`ifdef SPLIT_FRAME_DONE_EN
   logic          a_fd, b_fd;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: accepted count since reset and held output data
   int            k_a, k_b;
   logic [DW-1:0] m_a_p1, m_a_p2, m_b_p1, m_b_p2;

   split_2o #(.WIDTH(2), .DEPTH_1(2), .DEPTH_2(3), .DATA_WIDTH(DW)) dut_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
      .pxl_out_1(a_p1), .valid_out_1(a_v1), .pxl_out_2(a_p2),
`ifdef SPLIT_FRAME_DONE_EN
      .frame_done(a_fd),
`endif
      .valid_out_2(a_v2));

   split_2o #(.WIDTH(8), .DEPTH_1(1), .DEPTH_2(1), .DATA_WIDTH(DW)) dut_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
      .pxl_out_1(b_p1), .valid_out_1(b_v1), .pxl_out_2(b_p2),
`ifdef SPLIT_FRAME_DONE_EN
      .frame_done(b_fd),
`endif
      .valid_out_2(b_v2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      k_a = 0; k_b = 0;
      m_a_p1 = '0; m_a_p2 = '0; m_b_p1 = '0; m_b_p2 = '0;
   endtask

   // One cycle: drive, let the edge pass, then compare all outputs against the model
   task automatic step(input logic v, input logic [DW-1:0] d);
      bit ea1, ea2, eb1, eb2, efa, efb;
      valid_in = v;
      pxl_in   = d;
      @(posedge clk);
      #1;
      ea1 = 1'b0; ea2 = 1'b0; eb1 = 1'b0; eb2 = 1'b0; efa = 1'b0; efb = 1'b0;
      if (v) begin
         // config A: 5 channels per position, 4 positions per frame
         if ((k_a % 5) < 2) begin ea1 = 1'b1; m_a_p1 = d; end
         else               begin ea2 = 1'b1; m_a_p2 = d; end
         efa = ((k_a % 20) == 19);
         k_a++;
         // config B: 2 channels per position, 64 positions per frame
         if ((k_b % 2) == 0) begin eb1 = 1'b1; m_b_p1 = d; end
         else                begin eb2 = 1'b1; m_b_p2 = d; end
         efb = ((k_b % 128) == 127);
         k_b++;
      end
      chk("a_v1", 32'(a_v1), 32'(ea1));
      chk("a_v2", 32'(a_v2), 32'(ea2));
      chk("a_p1", a_p1, m_a_p1);
      chk("a_p2", a_p2, m_a_p2);
      chk("b_v1", 32'(b_v1), 32'(eb1));
      chk("b_v2", 32'(b_v2), 32'(eb2));
      chk("b_p1", b_p1, m_b_p1);
      chk("b_p2", b_p2, m_b_p2);
      chk("b_excl", 32'(b_v1 & b_v2), 32'd0);
`ifdef SPLIT_FRAME_DONE_EN
      chk("a_fd", 32'(a_fd), 32'(efa));
      chk("b_fd", 32'(b_fd), 32'(efb));
`else
      if (efa && efb) begin
         chk("a_v2_last", 32'(a_v2), 32'd1);
      end
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a_v1"}, 32'(a_v1), 32'd0);
      chk({tag, "_a_v2"}, 32'(a_v2), 32'd0);
      chk({tag, "_a_p1"}, a_p1, 32'd0);
      chk({tag, "_a_p2"}, a_p2, 32'd0);
      chk({tag, "_b_v1"}, 32'(b_v1), 32'd0);
      chk({tag, "_b_p2"}, b_p2, 32'd0);
`ifdef SPLIT_FRAME_DONE_EN
      chk({tag, "_a_fd"}, 32'(a_fd), 32'd0);
`endif
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      pxl_in   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b1;

      // Consecutive frame 0..19
      for (int i = 0; i < 20; i++) step(1'b1, DW'(i));
      // Same values with random gaps
      for (int i = 0; i < 20; i++) begin
         while ($urandom_range(2, 0) == 0) step(1'b0, DW'($urandom));
         step(1'b1, DW'(i));
      end
      // Two back-to-back frames 0..39
      for (int i = 0; i < 40; i++) step(1'b1, DW'(i));

      // Partial frame, then asynchronous reset mid-frame
      for (int i = 0; i < 8; i++) step(1'b1, DW'(i));
      #2;
      reset = 1'b0;
      #1;
      chk_zero("arst");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("arst_hold");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 100; i < 120; i++) step(1'b1, DW'(i));

      // Full frame of config B and beyond, then random traffic
      for (int i = 0; i < 140; i++) step(1'b1, DW'(1000 + i));
      for (int i = 0; i < 400; i++) step(1'($urandom_range(1, 0)), DW'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
